// File: rtl/fir_axil_master.sv
// fir_axil_master: AXI4-Lite initiator that turns single commands (write, read,
// poll) into AXI-Lite transactions toward the FIR configuration slave.
//
// Handshake rule used on every channel here: a transfer happens on the rising
// edge where VALID and READY are both high; VALID, once raised, stays high
// with stable payload until that edge, and READY carries no such obligation.
module fir_axil_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 12,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int POLL_MAX           = 1024,
    parameter int POLL_GAP           = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    // command port
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_data,
    // response port
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_data,
    output logic                          rsp_err,
    // AXI-Lite write address / data
    output logic [C_M_AXI_ADDR_WIDTH-1:0] AWADDR,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] WDATA,
    output logic                          WVALID,
    input  logic                          WREADY,
    // AXI-Lite read address / data
    output logic [C_M_AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] RDATA,
    input  logic                          RVALID,
    output logic                          RREADY,
    // FSM state for observation
    output logic [2:0]                    dbg_state
);

    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int DW  = C_M_AXI_DATA_WIDTH;
    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam int GCW = $clog2(POLL_GAP + 2);

    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD_A = 3'd2;
    localparam logic [2:0] S_RD_D = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;

    logic [2:0]     state_q,     state_d;
    logic [1:0]     op_q,        op_d;
    logic [AW-1:0]  addr_q,      addr_d;
    logic [DW-1:0]  data_q,      data_d;
    logic           awvalid_q,   awvalid_d;
    logic           wvalid_q,    wvalid_d;
    logic           arvalid_q,   arvalid_d;
    logic           rready_q,    rready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_data_q,  rsp_data_d;
    logic           rsp_err_q,   rsp_err_d;
    logic [PCW-1:0] poll_cnt_q,  poll_cnt_d;
    logic [GCW-1:0] gap_cnt_q,   gap_cnt_d;

    logic [PCW-1:0] poll_cnt_inc;
    logic           poll_hit;

    // Address and data registers feed both AXI channels; they only change at
    // command acceptance, so they are stable for the whole transaction.
    assign cmd_ready = (state_q == S_IDLE) && !ARESET;
    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = data_q;
    assign AWVALID   = awvalid_q;
    assign WVALID    = wvalid_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

    assign poll_cnt_inc = poll_cnt_q + 1'b1;
    assign poll_hit     = ((RDATA & data_q) == data_q);

    // Next-state and next-output computation for the command sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        poll_cnt_d  = poll_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = cmd_op;
                    addr_d     = cmd_addr;
                    data_d     = cmd_data;
                    poll_cnt_d = '0;
                    case (cmd_op)
                        OP_WR: begin
                            state_d   = S_WR;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end
                        OP_RD, OP_POLL: begin
                            state_d   = S_RD_A;
                            arvalid_d = 1'b1;
                        end
                        default: begin
                            state_d     = S_RSP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = '0;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_WR: begin
                // Each VALID retires on its own handshake; wait for both.
                awvalid_d = awvalid_q && !AWREADY;
                wvalid_d  = wvalid_q && !WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            S_RD_A: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_D;
                end
            end
            S_RD_D: begin
                if (RVALID) begin
                    rready_d   = 1'b0;
                    poll_cnt_d = poll_cnt_inc;
                    if ((op_q != OP_POLL) || poll_hit) begin
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = RDATA;
                        rsp_err_d   = 1'b0;
                    end else if (poll_cnt_inc == POLL_LAST) begin
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = RDATA;
                        rsp_err_d   = 1'b1;
                    end else if (POLL_GAP == 0) begin
                        state_d   = S_RD_A;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = S_RD_A;
                    arvalid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any outstanding transaction and response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WR;
            addr_q      <= '0;
            data_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            poll_cnt_q  <= poll_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_fir_axil_master.sv
// tb_fir_axil_master: table vectors, directed corner sequences and random
// commands against a reactive AXI-Lite slave and a behavioural reference.
`timescale 1ns/1ps
module tb_fir_axil_master;

    localparam int AW          = 12;
    localparam int DW          = 32;
    localparam int TB_POLL_MAX = 8;
    localparam int TB_POLL_GAP = 4;

    // ---------------- clock / reset ----------------
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic          WVALID;
    logic          WREADY;
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic          RVALID;
    logic          RREADY;
    logic [2:0]    dbg_state;

    fir_axil_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .POLL_MAX(TB_POLL_MAX),
        .POLL_GAP(TB_POLL_GAP)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reactive AXI-Lite slave ----------------
    // Latencies count negedges of VALID seen before READY is raised; in
    // both_mode the write channels only start counting once AWVALID and
    // WVALID have been seen high together.
    int            aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    bit            both_mode = 1'b0;
    logic [DW-1:0] rd_default = '0;
    logic [DW-1:0] rd_q[$];
    logic [AW-1:0] aw_log[$];
    logic [AW-1:0] ar_log[$];
    logic [DW-1:0] w_log[$];
    int            ar_first_q[$];
    int            r_hs_q[$];
    int            last_ar_hold = 0;

    initial begin : slave
        int  aw_wait, w_wait, ar_wait, r_wait, ar_hold;
        bit  both_seen, rd_active;
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0; ar_hold = 0;
        both_seen = 1'b0; rd_active = 1'b0;
        forever begin
            @(negedge ACLK);
            if (AWVALID && WVALID) both_seen = 1'b1;
            if (!AWVALID && !WVALID) both_seen = 1'b0;
            // AW
            if (AWREADY) begin
                AWREADY = 1'b0; aw_wait = 0;
            end else if (AWVALID && (!both_mode || both_seen)) begin
                aw_wait++;
                if (aw_wait > aw_lat) begin AWREADY = 1'b1; aw_log.push_back(AWADDR); end
            end else if (!AWVALID) begin
                aw_wait = 0;
            end
            // W
            if (WREADY) begin
                WREADY = 1'b0; w_wait = 0;
            end else if (WVALID && (!both_mode || both_seen)) begin
                w_wait++;
                if (w_wait > w_lat) begin WREADY = 1'b1; w_log.push_back(WDATA); end
            end else if (!WVALID) begin
                w_wait = 0;
            end
            // AR
            if (ARVALID) ar_hold++;
            if (ARREADY) begin
                ARREADY = 1'b0;
            end else if (ARVALID) begin
                if (ar_wait == 0) ar_first_q.push_back(cyc);
                ar_wait++;
                if (ar_wait > ar_lat) begin
                    ARREADY = 1'b1; ar_log.push_back(ARADDR);
                    last_ar_hold = ar_hold; ar_hold = 0; ar_wait = 0;
                    rd_active = 1'b1; r_wait = 0;
                end
            end else begin
                ar_wait = 0; ar_hold = 0;
            end
            // R
            if (RVALID) begin
                RVALID = 1'b0; RDATA = $urandom; rd_active = 1'b0;
            end else if (rd_active && !ARREADY) begin
                r_wait++;
                if (r_wait > r_lat) begin
                    RVALID = 1'b1;
                    RDATA = (rd_q.size() > 0) ? rd_q.pop_front() : rd_default;
                    r_hs_q.push_back(cyc);
                    check("rready_with_rvalid", {31'd0, RREADY}, 32'd1);
                end
            end
            if (RREADY && !rd_active) begin
                bad++; total++;
                $display("FAIL rready_early: got RREADY=1 expected 0 with no read in flight (cycle %0d)", cyc);
            end
        end
    end

    // ---------------- behavioural reference ----------------
    function automatic void ref_model(input logic [1:0] op, input logic [DW-1:0] d,
                                      input logic [DW-1:0] vals[16], input int nv,
                                      input logic [DW-1:0] rdef,
                                      output logic [DW-1:0] ed, output logic ee,
                                      output int nr, output int nw);
        logic [DW-1:0] v;
        ed = '0; ee = 1'b0; nr = 0; nw = 0;
        case (op)
            2'd0: nw = 1;
            2'd1: begin nr = 1; ed = (nv > 0) ? vals[0] : rdef; end
            2'd2: begin
                ee = 1'b1;
                for (int i = 0; i < TB_POLL_MAX; i++) begin
                    v = (i < nv) ? vals[i] : rdef;
                    nr++;
                    ed = v;
                    if ((v & d) == d) begin ee = 1'b0; break; end
                end
            end
            default: ee = 1'b1;
        endcase
    endfunction

    // ---------------- driver ----------------
    logic          v1_aw, v1_w, v1_ar;
    logic [AW-1:0] v1_awaddr, v1_araddr;
    logic [DW-1:0] v1_wdata;

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int hold, output logic [DW-1:0] rd, output logic er, output int lat);
        int n, c0;
        logic [DW-1:0] d0;
        logic e0;
        rd = 'x; er = 1'bx; lat = -1;
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        c0 = cyc;
        @(negedge ACLK);
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        v1_aw = AWVALID; v1_w = WVALID; v1_ar = ARVALID;
        v1_awaddr = AWADDR; v1_wdata = WDATA; v1_araddr = ARADDR;
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge ACLK); n++; end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        lat = cyc - c0;
        d0 = rsp_data; e0 = rsp_err;
        for (int h = 0; h < hold; h++) begin
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("hold_rsp_data", rsp_data, d0);
            check("hold_rsp_err", {31'd0, rsp_err}, {31'd0, e0});
            @(negedge ACLK);
        end
        rd = rsp_data; er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        check("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] r0, r1, r2;
        int            nr;
        logic [DW-1:0] rdef;
        int            awl, wl, arl, rl;
        bit            both;
        int            hold;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            exp_reads;
        int            exp_writes;
        int            exp_lat;     // -1: not checked
        int            exp_arhold;  // -1: not checked
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string name, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                           input logic [DW-1:0] r2, input int nr, input logic [DW-1:0] rdef,
                           input int awl, input int wl, input int arl, input int rl, input bit both,
                           input int hold, input logic [DW-1:0] exp_data, input logic exp_err,
                           input int exp_reads, input int exp_writes, input int exp_lat, input int exp_arhold);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.data = data;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.nr = nr; v.rdef = rdef;
        v.awl = awl; v.wl = wl; v.arl = arl; v.rl = rl; v.both = both; v.hold = hold;
        v.exp_data = exp_data; v.exp_err = exp_err; v.exp_reads = exp_reads;
        v.exp_writes = exp_writes; v.exp_lat = exp_lat; v.exp_arhold = exp_arhold;
        vq.push_back(v);
    endtask

    task automatic set_slave(input int awl, input int wl, input int arl, input int rl,
                             input bit both, input logic [DW-1:0] rdef);
        aw_lat = awl; w_lat = wl; ar_lat = arl; r_lat = rl; both_mode = both; rd_default = rdef;
        rd_q.delete();
    endtask

    task automatic apply_vec(input vec_t v);
        int b_ar, b_aw, b_w, b_af, b_rh, lat;
        logic [DW-1:0] rd;
        logic er;
        set_slave(v.awl, v.wl, v.arl, v.rl, v.both, v.rdef);
        if (v.nr > 0) rd_q.push_back(v.r0);
        if (v.nr > 1) rd_q.push_back(v.r1);
        if (v.nr > 2) rd_q.push_back(v.r2);
        b_ar = ar_log.size(); b_aw = aw_log.size(); b_w = w_log.size();
        b_af = ar_first_q.size(); b_rh = r_hs_q.size();
        run_cmd(v.op, v.addr, v.data, v.hold, rd, er, lat);
        check({v.name, "_data"}, rd, v.exp_data);
        check({v.name, "_err"}, {31'd0, er}, {31'd0, v.exp_err});
        check({v.name, "_reads"}, 32'(ar_log.size() - b_ar), 32'(v.exp_reads));
        check({v.name, "_aw"}, 32'(aw_log.size() - b_aw), 32'(v.exp_writes));
        check({v.name, "_w"}, 32'(w_log.size() - b_w), 32'(v.exp_writes));
        if (v.exp_lat >= 0) check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        if (v.op == 2'd0) begin
            check({v.name, "_awvalid_t1"}, {31'd0, v1_aw}, 32'd1);
            check({v.name, "_wvalid_t1"}, {31'd0, v1_w}, 32'd1);
            check({v.name, "_awaddr"}, {20'd0, v1_awaddr}, {20'd0, v.addr});
            check({v.name, "_wdata"}, v1_wdata, v.data);
            if (aw_log.size() > b_aw) check({v.name, "_aw_hs_addr"}, {20'd0, aw_log[$]}, {20'd0, v.addr});
            if (w_log.size() > b_w) check({v.name, "_w_hs_data"}, w_log[$], v.data);
        end
        if (v.op == 2'd1 || v.op == 2'd2) begin
            check({v.name, "_arvalid_t1"}, {31'd0, v1_ar}, 32'd1);
            check({v.name, "_araddr"}, {20'd0, v1_araddr}, {20'd0, v.addr});
            for (int i = b_ar; i < ar_log.size(); i++)
                check({v.name, "_ar_hs_addr"}, {20'd0, ar_log[i]}, {20'd0, v.addr});
            for (int i = 1; i < v.exp_reads; i++)
                if ((b_af + i) < ar_first_q.size() && (b_rh + i - 1) < r_hs_q.size())
                    check({v.name, "_gap"}, 32'(ar_first_q[b_af + i] - r_hs_q[b_rh + i - 1] - 1),
                          32'(TB_POLL_GAP));
        end
        if (v.op == 2'd3) begin
            check({v.name, "_no_aw"}, {31'd0, v1_aw | v1_w}, 32'd0);
            check({v.name, "_no_ar"}, {31'd0, v1_ar}, 32'd0);
        end
        if (v.exp_arhold >= 0) check({v.name, "_arvalid_cycles"}, 32'(last_ar_hold), 32'(v.exp_arhold));
    endtask

    // ---------------- random commands against the reference ----------------
    task automatic rand_test(input int count);
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data, rdef, ed, rd;
        logic [DW-1:0] vals[16];
        logic          ee, er;
        int            nv, nr, nw, b_ar, b_aw, r, lat;
        for (int n = 0; n < count; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            addr = AW'($urandom_range(0, 4095)) & 12'hFFC;
            nv = $urandom_range(0, 10);
            for (int i = 0; i < 16; i++) vals[i] = (op == 2'd2) ? DW'($urandom_range(0, 15)) : DW'($urandom);
            rdef = (op == 2'd2) ? DW'($urandom_range(0, 15)) : DW'($urandom);
            data = (op == 2'd2) ? DW'($urandom_range(0, 7)) : DW'($urandom);
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), rdef);
            for (int i = 0; i < nv; i++) rd_q.push_back(vals[i]);
            ref_model(op, data, vals, nv, rdef, ed, ee, nr, nw);
            exp_q.push_back(ed);
            b_ar = ar_log.size(); b_aw = aw_log.size();
            run_cmd(op, addr, data, $urandom_range(0, 2), rd, er, lat);
            check("rnd_data", rd, exp_q.pop_front());
            check("rnd_err", {31'd0, er}, {31'd0, ee});
            check("rnd_reads", 32'(ar_log.size() - b_ar), 32'(nr));
            check("rnd_writes", 32'(aw_log.size() - b_aw), 32'(nw));
            if (nw == 1 && aw_log.size() > b_aw) begin
                check("rnd_awaddr", {20'd0, aw_log[$]}, {20'd0, addr});
                check("rnd_wdata", w_log[$], data);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [DW-1:0] rd;
        logic er;
        int lat, b_aw, n;

        // reset state
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst_awvalid", {31'd0, AWVALID}, 32'd0);
        check("rst_wvalid", {31'd0, WVALID}, 32'd0);
        check("rst_arvalid", {31'd0, ARVALID}, 32'd0);
        check("rst_rready", {31'd0, RREADY}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_awaddr", {20'd0, AWADDR}, 32'd0);
        check("rst_araddr", {20'd0, ARADDR}, 32'd0);
        check("rst_wdata", WDATA, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        ARESET = 1'b0;
        #1;
        check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        //       name        op    addr    data          r0     r1     r2    nr rdef           awl wl arl rl both hold exp_data       err rd wr lat arhold
        add_vec("wr_len",    2'd0, 12'h010, 32'h0000_0258, '0,    '0,    '0,    0, '0,            1, 1, 0, 0, 0,   0,   32'h0,         0,  0, 1, 3,  -1);
        add_vec("wr_fast",   2'd0, 12'h000, 32'h0000_0001, '0,    '0,    '0,    0, '0,            0, 0, 0, 0, 0,   1,   32'h0,         0,  0, 1, 2,  -1);
        add_vec("wr_both",   2'd0, 12'h024, 32'hA5A5_0F0F, '0,    '0,    '0,    0, '0,            2, 0, 0, 0, 1,   0,   32'h0,         0,  0, 1, 4,  -1);
        add_vec("rd_slow",   2'd1, 12'h020, 32'h0,         '0,    '0,    '0,    0, 32'hFFFF_FFF6, 0, 0, 3, 1, 0,   0,   32'hFFFF_FFF6, 0,  1, 0, 7,  4);
        add_vec("rd_fast",   2'd1, 12'h004, 32'h0,         '0,    '0,    '0,    0, 32'h1234_5678, 0, 0, 0, 0, 0,   0,   32'h1234_5678, 0,  1, 0, 3,  1);
        add_vec("rd_top",    2'd1, 12'hFFC, 32'h0,         32'h7, '0,    '0,    1, 32'h0,         0, 0, 1, 0, 0,   2,   32'h7,         0,  1, 0, 4,  2);
        add_vec("poll_hit3", 2'd2, 12'h000, 32'h2,         32'h0, 32'h0, 32'h6, 3, 32'h0,         0, 0, 0, 0, 0,   0,   32'h6,         0,  3, 0, -1, -1);
        add_vec("poll_tmo",  2'd2, 12'h000, 32'h2,         '0,    '0,    '0,    0, 32'h4,         0, 0, 1, 1, 0,   0,   32'h4,         1,  8, 0, -1, -1);
        add_vec("poll_m0",   2'd2, 12'h000, 32'h0,         '0,    '0,    '0,    0, 32'h0,         0, 0, 0, 0, 0,   0,   32'h0,         0,  1, 0, 3,  -1);
        add_vec("poll_m3",   2'd2, 12'h000, 32'h3,         32'h1, 32'h2, 32'h3, 3, 32'h0,         0, 0, 0, 2, 0,   0,   32'h3,         0,  3, 0, -1, -1);
        add_vec("illegal",   2'd3, 12'h010, 32'hDEAD_BEEF, '0,    '0,    '0,    0, '0,            0, 0, 0, 0, 0,   5,   32'h0,         1,  0, 0, 1,  -1);
        foreach (vq[i]) apply_vec(vq[i]);

        // reset while the write waits on WREADY
        set_slave(0, 50, 0, 0, 0, '0);
        b_aw = aw_log.size();
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 12'h008; cmd_data = 32'h1111_2222;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        cmd_valid = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        check("mid_wvalid_waiting", {31'd0, WVALID}, 32'd1);
        check("mid_awvalid_done", {31'd0, AWVALID}, 32'd0);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("arst_awvalid", {31'd0, AWVALID}, 32'd0);
        check("arst_wvalid", {31'd0, WVALID}, 32'd0);
        check("arst_arvalid", {31'd0, ARVALID}, 32'd0);
        check("arst_rready", {31'd0, RREADY}, 32'd0);
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        ARESET = 1'b0;
        #1;
        check("arst_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check("arst_aw_count", 32'(aw_log.size() - b_aw), 32'd1);
        set_slave(0, 0, 0, 0, 0, '0);
        run_cmd(2'd0, 12'h00C, 32'h3333_4444, 0, rd, er, lat);
        check("post_rst_data", rd, 32'h0);
        check("post_rst_err", {31'd0, er}, 32'd0);
        check("post_rst_latency", 32'(lat), 32'd2);
        check("post_rst_wdata", w_log[$], 32'h3333_4444);

        rand_test(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
